// File: rtl/cpu_run_pkg.sv
// Shared types and helpers for the CPU run/reset sequencer.
package cpu_run_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HOLD      = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    STEP_WAIT = 3'd4,
    DONE      = 3'd5
  } run_state_t;

  // Stage timer must hold the larger of the hold time and the release gap.
  function automatic int unsigned timer_w(input int unsigned hold, input int unsigned gap);
    return $clog2(((hold > gap) ? hold : gap) + 1);
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Control/status bundle between a host (master) and the run sequencer (slave).
interface cpu_run_ctrl_if #(
  parameter int unsigned N_RST = 2,
  parameter int unsigned CNT_W = 32
) ();

  logic             start;
  logic             stop;
  logic             step_mode;
  logic             step;
  logic [N_RST-1:0] rst_out;
  logic             cpu_en;
  logic [CNT_W-1:0] cycle_cnt;
  logic             done;
  logic [2:0]       state_o;

  modport master (
    output start, stop, step_mode, step,
    input  rst_out, cpu_en, cycle_cnt, done, state_o
  );

  modport slave (
    input  start, stop, step_mode, step,
    output rst_out, cpu_en, cycle_cnt, done, state_o
  );

endinterface

// File: rtl/cpu_run_ctrl_stage_timer.sv
// Loadable down-counter; expire_c is high during the last cycle of a loaded interval.
module cpu_run_ctrl_stage_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expire_c
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  // A load of V yields exactly V cycles before the FSM acts on expiry.
  assign expire_c = (cnt == W'(1));

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/reset sequencer: staged release of downstream resets, then gated CPU clock enable.
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int unsigned N_RST       = 2,
  parameter int unsigned HOLD_CYCLES = 100,
  parameter int unsigned STAGE_GAP   = 4,
  parameter int unsigned RUN_LIMIT   = 1000,
  parameter int unsigned CNT_W       = 32
) (
  input logic           clk,
  input logic           reset,
  cpu_run_ctrl_if.slave bus
);

  localparam int unsigned TMR_W = timer_w(HOLD_CYCLES, STAGE_GAP);
  localparam int unsigned IDX_W = $clog2(N_RST + 1);

  run_state_t       state, state_nxt;
  logic [N_RST-1:0] rst_q, rst_nxt;
  logic             cpu_en_q, cpu_en_nxt;
  logic             done_q;
  logic [CNT_W-1:0] cnt_q;
  logic             cnt_clr;
  logic [IDX_W-1:0] idx_q, idx_nxt;
  logic             step_q;
  logic             step_rise_c;
  logic             limit_hit_c;
  logic             go_c;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_value;
  logic             tmr_expire_c;

  cpu_run_ctrl_stage_timer #(.W(TMR_W)) u_stage_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .value    (tmr_value),
    .expire_c (tmr_expire_c)
  );

  assign step_rise_c = bus.step & ~step_q;
  assign go_c        = bus.start & ~bus.stop;
  // Current enabled cycle is the last one allowed by the limit.
  assign limit_hit_c = (RUN_LIMIT != 0) && cpu_en_q &&
                       ((64'(cnt_q) + 64'd1) >= 64'(RUN_LIMIT));

  // Next-state and next-output decode
  always_comb begin
    state_nxt  = state;
    rst_nxt    = rst_q;
    cpu_en_nxt = 1'b0;
    cnt_clr    = 1'b0;
    idx_nxt    = idx_q;
    tmr_load   = 1'b0;
    tmr_value  = TMR_W'(STAGE_GAP);

    case (state)
      IDLE, DONE: begin
        if (go_c) begin
          state_nxt = HOLD;
          rst_nxt   = '1;
          cnt_clr   = 1'b1;
          tmr_load  = 1'b1;
          tmr_value = TMR_W'(HOLD_CYCLES);
        end
      end
      HOLD: begin
        if (bus.stop) begin
          state_nxt = IDLE;
          rst_nxt   = '1;
        end else if (tmr_expire_c) begin
          state_nxt  = RELEASE;
          rst_nxt[0] = 1'b0;
          idx_nxt    = IDX_W'(1);
          tmr_load   = 1'b1;
        end
      end
      RELEASE: begin
        if (bus.stop) begin
          state_nxt = IDLE;
          rst_nxt   = '1;
        end else if (tmr_expire_c) begin
          if (idx_q == IDX_W'(N_RST)) begin
            state_nxt  = bus.step_mode ? STEP_WAIT : RUN;
            cpu_en_nxt = ~bus.step_mode;
          end else begin
            for (int unsigned i = 0; i < N_RST; i++) begin
              if (idx_q == IDX_W'(i)) rst_nxt[i] = 1'b0;
            end
            idx_nxt  = idx_q + IDX_W'(1);
            tmr_load = 1'b1;
          end
        end
      end
      RUN: begin
        if (bus.stop || limit_hit_c) begin
          state_nxt = DONE;
        end else if (bus.step_mode) begin
          state_nxt = STEP_WAIT;
        end else begin
          cpu_en_nxt = 1'b1;
        end
      end
      STEP_WAIT: begin
        if (bus.stop || limit_hit_c) begin
          state_nxt = DONE;
        end else if (!bus.step_mode) begin
          // A coincident step edge is absorbed into the first RUN cycle.
          state_nxt  = RUN;
          cpu_en_nxt = 1'b1;
        end else begin
          cpu_en_nxt = step_rise_c;
        end
      end
      default: begin
        state_nxt = IDLE;
        rst_nxt   = '1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Registered outputs and datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rst_q    <= '1;
      cpu_en_q <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      idx_q    <= '0;
      step_q   <= 1'b0;
    end else begin
      rst_q    <= rst_nxt;
      cpu_en_q <= cpu_en_nxt;
      done_q   <= (state_nxt == DONE);
      idx_q    <= idx_nxt;
      step_q   <= bus.step;
      if (cnt_clr) begin
        cnt_q <= '0;
      end else if (cpu_en_q && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.rst_out   = rst_q;
  assign bus.cpu_en    = cpu_en_q;
  assign bus.cycle_cnt = cnt_q;
  assign bus.done      = done_q;
  assign bus.state_o   = state;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench: two sequencers (limited / unlimited 4-bit count) share one random stimulus stream.
module tb_cpu_run_ctrl;
  import cpu_run_pkg::*;

  localparam int HOLD_C = 4;
  localparam int GAP_C  = 2;
  localparam int NR     = 2;
  localparam int LIM_A  = 8;
  localparam int CW_A   = 32;
  localparam int LIM_B  = 0;
  localparam int CW_B   = 4;
  localparam int T_RUN  = HOLD_C + NR * GAP_C + 1;

  localparam int M_IDLE = 0, M_SEQ = 1, M_RUN = 2, M_STEP = 3, M_DONE = 4;

  typedef struct {
    int     ph;
    int     t;
    bit     en;
    longint cnt;
    bit     prev;
  } mst_t;

  typedef struct packed {
    logic [1:0]  rst;
    logic        en;
    logic [63:0] cnt;
    logic        done;
    logic [2:0]  st;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic sm_v = 1'b0;
  bit   armed = 1'b0;
  int   total = 0;
  int   bad = 0;
  mst_t ma, mb;
  exp_t qa[$];
  exp_t qb[$];
  exp_t rst_exp;

  cpu_run_ctrl_if #(.N_RST(NR), .CNT_W(CW_A)) bus_a ();
  cpu_run_ctrl_if #(.N_RST(NR), .CNT_W(CW_B)) bus_b ();

  cpu_run_ctrl #(.N_RST(NR), .HOLD_CYCLES(HOLD_C), .STAGE_GAP(GAP_C),
                 .RUN_LIMIT(LIM_A), .CNT_W(CW_A)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  cpu_run_ctrl #(.N_RST(NR), .HOLD_CYCLES(HOLD_C), .STAGE_GAP(GAP_C),
                 .RUN_LIMIT(LIM_B), .CNT_W(CW_B)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  always #5 clk = ~clk;

  // Reference: sequence timing from elapsed cycles since start, run rules per enabled cycle.
  function automatic mst_t mstep(input mst_t s, input logic rs, input logic st, input logic sp,
                                 input logic sm, input logic stp, input int limit, input int cw);
    mst_t   n;
    longint mx;
    longint nc;
    bit     lim;
    mx  = (longint'(1) << cw) - 1;
    nc  = (s.en && s.cnt != mx) ? s.cnt + 1 : s.cnt;
    lim = (limit != 0) && s.en && (nc >= longint'(limit));
    if (rs) begin
      n = '{ph: M_IDLE, t: 0, en: 1'b0, cnt: 0, prev: 1'b0};
      return n;
    end
    n = s;
    n.prev = stp;
    n.cnt  = nc;
    n.en   = 1'b0;
    case (s.ph)
      M_IDLE, M_DONE: if (st && !sp) begin n.ph = M_SEQ; n.t = 1; n.cnt = 0; end
      M_SEQ: begin
        if (sp) n.ph = M_IDLE;
        else begin
          n.t = s.t + 1;
          if (n.t == T_RUN) begin n.ph = sm ? M_STEP : M_RUN; n.en = !sm; end
        end
      end
      M_RUN: begin
        if (sp || lim) n.ph = M_DONE;
        else if (sm) n.ph = M_STEP;
        else n.en = 1'b1;
      end
      M_STEP: begin
        if (sp || lim) n.ph = M_DONE;
        else if (!sm) begin n.ph = M_RUN; n.en = 1'b1; end
        else n.en = stp && !s.prev;
      end
      default: n.ph = M_IDLE;
    endcase
    return n;
  endfunction

  function automatic exp_t mexp(input mst_t s);
    exp_t e;
    e.en   = s.en;
    e.cnt  = 64'(s.cnt);
    e.done = (s.ph == M_DONE);
    e.rst  = 2'b00;
    case (s.ph)
      M_IDLE: begin e.rst = 2'b11; e.st = IDLE; end
      M_SEQ: begin
        for (int i = 0; i < NR; i++) e.rst[i] = !(s.t >= HOLD_C + 1 + i * GAP_C);
        e.st = (s.t <= HOLD_C) ? HOLD : RELEASE;
      end
      M_RUN:  e.st = RUN;
      M_STEP: e.st = STEP_WAIT;
      default: e.st = DONE;
    endcase
    return e;
  endfunction

  function automatic exp_t act_a();
    return '{rst: bus_a.rst_out, en: bus_a.cpu_en, cnt: 64'(bus_a.cycle_cnt),
             done: bus_a.done, st: bus_a.state_o};
  endfunction

  function automatic exp_t act_b();
    return '{rst: bus_b.rst_out, en: bus_b.cpu_en, cnt: 64'(bus_b.cycle_cnt),
             done: bus_b.done, st: bus_b.state_o};
  endfunction

  task automatic cmp_exp(input string nm, input exp_t act, input exp_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got rst=%b en=%b cnt=%0d done=%b st=%0d, want rst=%b en=%b cnt=%0d done=%b st=%0d",
               nm, $time, act.rst, act.en, act.cnt, act.done, act.st,
               exp.rst, exp.en, exp.cnt, exp.done, exp.st);
    end
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s @%0t: got %0d, want %0d", nm, $time, act, exp);
    end
  endtask

  // Monitor: one expected snapshot per DUT per clock edge.
  always begin
    @(posedge clk);
    #1;
    if (armed) begin
      if (qa.size() == 0) chk("scoreboard_a_underflow", 1, 0);
      else cmp_exp("cycle_a", act_a(), qa.pop_front());
      if (qb.size() == 0) chk("scoreboard_b_underflow", 1, 0);
      else cmp_exp("cycle_b", act_b(), qb.pop_front());
    end
  end

  task automatic cyc(input logic rs, input logic st, input logic sp, input logic stp);
    @(negedge clk);
    reset = rs;
    bus_a.start = st; bus_a.stop = sp; bus_a.step_mode = sm_v; bus_a.step = stp;
    bus_b.start = st; bus_b.stop = sp; bus_b.step_mode = sm_v; bus_b.step = stp;
    ma = mstep(ma, rs, st, sp, sm_v, stp, LIM_A, CW_A);
    mb = mstep(mb, rs, st, sp, sm_v, stp, LIM_B, CW_B);
    qa.push_back(mexp(ma));
    qb.push_back(mexp(mb));
    armed = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_exp = '{rst: 2'b11, en: 1'b0, cnt: 64'd0, done: 1'b0, st: IDLE};
    ma = '{ph: M_IDLE, t: 0, en: 1'b0, cnt: 0, prev: 1'b0};
    mb = ma;
    bus_a.start = 1'b0; bus_a.stop = 1'b0; bus_a.step_mode = 1'b0; bus_a.step = 1'b0;
    bus_b.start = 1'b0; bus_b.stop = 1'b0; bus_b.step_mode = 1'b0; bus_b.step = 1'b0;
    #1 reset = 1'b1;
    #1;
    cmp_exp("reset_a", act_a(), rst_exp);
    cmp_exp("reset_b", act_b(), rst_exp);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);

    // Full sequence; A stops at its limit, B keeps running and saturates
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    idle(17);
    settle();
    chk("seq_cnt_a", longint'(bus_a.cycle_cnt), 8);
    chk("seq_done_a", longint'(bus_a.done), 1);
    idle(8);
    settle();
    chk("sat_cnt_b", longint'(bus_b.cycle_cnt), 15);
    chk("sat_en_b", longint'(bus_b.cpu_en), 1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    settle();
    chk("stop_done_b", longint'(bus_b.done), 1);
    chk("stop_en_b", longint'(bus_b.cpu_en), 0);

    // Restart from DONE, then async reset mid-run
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    settle();
    chk("restart_rst_a", longint'(bus_a.rst_out), 3);
    chk("restart_done_a", longint'(bus_a.done), 0);
    chk("restart_cnt_a", longint'(bus_a.cycle_cnt), 0);
    idle(12);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    cmp_exp("async_reset_a", act_a(), rst_exp);
    cmp_exp("async_reset_b", act_b(), rst_exp);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);

    // Abort during release
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    idle(5);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    settle();
    chk("abort_rst_a", longint'(bus_a.rst_out), 3);
    chk("abort_state_a", longint'(bus_a.state_o), longint'(IDLE));
    idle(4);

    // start+stop together, then start during RUN
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    settle();
    chk("start_stop_state_a", longint'(bus_a.state_o), longint'(IDLE));
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    idle(11);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    settle();
    chk("start_in_run_state_a", longint'(bus_a.state_o), longint'(RUN));
    idle(1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);

    // Single-step: three edges 3 cycles apart, then free-run to the limit
    sm_v = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    idle(9);
    repeat (3) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
    end
    idle(2);
    settle();
    chk("step_cnt_a", longint'(bus_a.cycle_cnt), 3);
    chk("step_state_a", longint'(bus_a.state_o), longint'(STEP_WAIT));
    sm_v = 1'b0;
    idle(6);
    settle();
    chk("step_done_a", longint'(bus_a.done), 1);
    chk("step_final_cnt_a", longint'(bus_a.cycle_cnt), 8);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);

    // Step edge coincident with leaving step mode
    sm_v = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    idle(10);
    sm_v = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    idle(3);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);

    // Randomized traffic
    for (int k = 0; k < 700; k++) begin
      if ($urandom_range(0, 24) == 0) sm_v = ~sm_v;
      cyc(logic'($urandom_range(0, 199) == 0), logic'($urandom_range(0, 9) == 0),
          logic'($urandom_range(0, 39) == 0), logic'($urandom_range(0, 1)));
    end

    sm_v = 1'b0;
    idle(2);
    settle();
    armed = 1'b0;
    chk("queue_a_drained", longint'(qa.size()), 0);
    chk("queue_b_drained", longint'(qb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
